icache_way_fill_ctrl: RTL and testbench

- Port sequencer for one L1 instruction-cache way SRAM: 128 x 64-bit words, single port, 8 byte-write masks, registered inputs, active-low chip select and write enable.
- Serves fetch-stage read lookups and runs line refills from the memory side, writing 4-beat lines into the way.
- Sits between the fetch/tag logic and the way SRAM macro; owns that SRAM's only port.

---
 rtl/icache_pkg.sv | 34 +++
 rtl/icache_rsp_pipe.sv | 30 +++
 rtl/icache_way_fill_ctrl.sv | 149 ++++++++++++++
 tb/tb_icache_way_fill_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
// icache_pkg: shared geometry, fill FSM encoding and address helper for the
//             I-cache way fill controller.
// Revision: 1.0
// ============================================================================
package icache_pkg;

  localparam int ADDR_WIDTH     = 7;
  localparam int DATA_WIDTH     = 64;
  localparam int NUM_WMASKS     = DATA_WIDTH / 8;
  localparam int WORDS_PER_LINE = 4;
  localparam int WORD_BITS      = $clog2(WORDS_PER_LINE);
  localparam int SET_BITS       = ADDR_WIDTH - WORD_BITS;

  // Cycles from read handshake to data on sram_dout0 (registered inputs + array).
  localparam int RD_LATENCY     = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FILL = 2'd2,
    ST_DONE = 2'd3
  } fill_state_e;

  function automatic logic [ADDR_WIDTH-1:0] line_word_addr(
    input logic [SET_BITS-1:0]  set,
    input logic [WORD_BITS-1:0] word
  );
    return {set, word};
  endfunction

endpackage : icache_pkg
`default_nettype wire

// File: rtl/icache_rsp_pipe.sv
`default_nettype none
// ============================================================================
// icache_rsp_pipe: valid shift register tracking reads through the way SRAM.
// Revision: 1.0
// ============================================================================
module icache_rsp_pipe
  import icache_pkg::*;
#(
  parameter int DEPTH = RD_LATENCY
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic out_valid
);

  logic [DEPTH-1:0] r_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe <= '0;
    end else begin
      r_pipe <= {r_pipe[DEPTH-2:0], in_valid};
    end
  end

  assign out_valid = r_pipe[DEPTH-1];

endmodule : icache_rsp_pipe
`default_nettype wire

// File: rtl/icache_way_fill_ctrl.sv
`default_nettype none
// ============================================================================
// icache_way_fill_ctrl: owns the single port of one I-cache way SRAM, serving
//   fetch reads and 4-beat line refills. Optional ICACHE_CRITICAL_WORD_FIRST_EN
//   starts each refill at the missed word.
// Revision: 1.0
// ============================================================================
module icache_way_fill_ctrl
  import icache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,

  input  logic                  miss_valid,
  output logic                  miss_ready,
  input  logic [SET_BITS-1:0]   miss_set,
  input  logic [WORD_BITS-1:0]  miss_word,

  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [SET_BITS-1:0]   mem_req_set,
  output logic [WORD_BITS-1:0]  mem_req_word,
  input  logic                  mem_rsp_valid,
  output logic                  mem_rsp_ready,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  output logic                  fill_done,

  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  fill_state_e          r_state;
  fill_state_e          w_state_nxt;

  logic [SET_BITS-1:0]  r_set;
  logic [WORD_BITS-1:0] r_start;
  logic [WORD_BITS-1:0] r_cnt;
  logic [WORD_BITS-1:0] w_beat;
  logic [WORD_BITS-1:0] w_start_word;

  logic                 w_idle;
  logic                 w_miss_fire;
  logic                 w_rd_fire;
  logic                 w_req_fire;
  logic                 w_beat_fire;
  logic                 w_last_beat;

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  assign w_start_word = miss_word;
`else
  logic unused_miss_word;
  assign unused_miss_word = ^miss_word;
  assign w_start_word     = '0;
`endif

  // Handshakes are gated by rst_n so the port goes quiet the moment reset asserts.
  assign w_idle      = rst_n && (r_state == ST_IDLE);
  assign w_miss_fire = w_idle && miss_valid;
  assign w_rd_fire   = w_idle && !miss_valid && rd_valid;
  assign w_req_fire  = (r_state == ST_REQ) && mem_req_ready;
  assign w_beat_fire = (r_state == ST_FILL) && mem_rsp_valid;
  assign w_last_beat = (r_cnt == WORD_BITS'(WORDS_PER_LINE - 1));
  assign w_beat      = r_start + r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_miss_fire) w_state_nxt = ST_REQ;
      ST_REQ:  if (w_req_fire) w_state_nxt = ST_FILL;
      ST_FILL: if (w_beat_fire && w_last_beat) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // r_cnt counts issued beats; the SRAM word index is r_start + r_cnt modulo the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_set   <= '0;
      r_start <= '0;
      r_cnt   <= '0;
    end else if (w_miss_fire) begin
      r_set   <= miss_set;
      r_start <= w_start_word;
      r_cnt   <= '0;
    end else if (w_beat_fire) begin
      r_cnt   <= r_cnt + WORD_BITS'(1);
    end
  end

  always_comb begin
    rd_ready      = w_idle && !miss_valid;
    miss_ready    = w_idle;
    mem_req_valid = (r_state == ST_REQ);
    mem_rsp_ready = (r_state == ST_FILL);
    fill_done     = (r_state == ST_DONE);

    sram_csb0     = 1'b1;
    sram_web0     = 1'b1;
    sram_wmask0   = '0;
    sram_addr0    = '0;
    sram_din0     = '0;

    if (w_beat_fire) begin
      sram_csb0   = 1'b0;
      sram_web0   = 1'b0;
      sram_wmask0 = '1;
      sram_addr0  = line_word_addr(r_set, w_beat);
      sram_din0   = mem_rsp_data;
    end else if (w_rd_fire) begin
      sram_csb0   = 1'b0;
      sram_addr0  = rd_addr;
    end
  end

  assign mem_req_set  = r_set;
  assign mem_req_word = r_start;

  icache_rsp_pipe #(
    .DEPTH (RD_LATENCY)
  ) u_rsp_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (w_rd_fire),
    .out_valid (rsp_valid)
  );

  assign rsp_data = sram_dout0;

endmodule : icache_way_fill_ctrl
`default_nettype wire

// File: tb/tb_icache_way_fill_ctrl.sv
`default_nettype none
// ============================================================================
// tb_icache_way_fill_ctrl: directed bench with a behavioural way-SRAM model.
// Revision: 1.0
// ============================================================================
module tb_icache_way_fill_ctrl;
  import icache_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  rd_valid, rd_ready, rsp_valid;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  miss_valid, miss_ready;
  logic [SET_BITS-1:0]   miss_set;
  logic [WORD_BITS-1:0]  miss_word;
  logic                  mem_req_valid, mem_req_ready;
  logic [SET_BITS-1:0]   mem_req_set;
  logic [WORD_BITS-1:0]  mem_req_word;
  logic                  mem_rsp_valid, mem_rsp_ready;
  logic [DATA_WIDTH-1:0] mem_rsp_data;
  logic                  fill_done;
  logic                  sram_csb0, sram_web0;
  logic [NUM_WMASKS-1:0] sram_wmask0;
  logic [ADDR_WIDTH-1:0] sram_addr0;
  logic [DATA_WIDTH-1:0] sram_din0, sram_dout0;

  int checks = 0;
  int errors = 0;

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  localparam logic [1:0] CWF_REQ_WORD = 2'd3;
  localparam logic [6:0] CWF_ADDR [4] = '{7'd7, 7'd4, 7'd5, 7'd6};
  localparam logic [63:0] CWF_RD5 = 64'hB2;
`else
  localparam logic [1:0] CWF_REQ_WORD = 2'd0;
  localparam logic [6:0] CWF_ADDR [4] = '{7'd4, 7'd5, 7'd6, 7'd7};
  localparam logic [63:0] CWF_RD5 = 64'hB1;
`endif

  always #5 clk = ~clk;

  icache_way_fill_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_set(miss_set), .miss_word(miss_word),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_set(mem_req_set), .mem_req_word(mem_req_word),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_data(mem_rsp_data),
    .fill_done(fill_done),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
  );

  // Way SRAM model: inputs registered, array access one edge later.
  logic [63:0] mem [128];
  logic        m_csb = 1'b1, m_web = 1'b1;
  logic [7:0]  m_wm;
  logic [6:0]  m_a;
  logic [63:0] m_d, m_dout;
  logic        pre_en = 1'b0;
  logic [6:0]  pre_addr;
  logic [63:0] pre_data;

  always @(posedge clk) begin
    if (!m_csb && m_web) m_dout <= mem[m_a];
    if (pre_en) begin
      mem[pre_addr] <= pre_data;
    end else if (!m_csb && !m_web) begin
      for (int b = 0; b < 8; b++) if (m_wm[b]) mem[m_a][b*8 +: 8] <= m_d[b*8 +: 8];
    end
    m_csb <= sram_csb0; m_web <= sram_web0; m_wm <= sram_wmask0;
    m_a   <= sram_addr0; m_d <= sram_din0;
  end
  assign sram_dout0 = m_dout;

  function automatic logic [63:0] bg(input int i);
    return {32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i)};
  endfunction

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic mid();  @(negedge clk);     endtask

  task automatic idle_inputs();
    rd_valid = 0; rd_addr = '0; miss_valid = 0; miss_set = '0; miss_word = '0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = '0;
  endtask

  task automatic test_reset();
    rst_n = 0; rd_valid = 1; rd_addr = 7'h33; miss_valid = 0; miss_set = '0; miss_word = '0;
    mem_req_ready = 1; mem_rsp_valid = 1; mem_rsp_data = 64'hFFFF;
    for (int i = 0; i < 128; i++) begin
      pre_en = 1; pre_addr = 7'(i);
      pre_data = (i == 5) ? 64'hDEADBEEF_CAFEF00D : bg(i);
      tick();
    end
    pre_en = 0;
    mid();
    checks++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL reset_rd_ready got %b exp 0", rd_ready); end
    checks++; if (miss_ready !== 1'b0) begin errors++; $display("FAIL reset_miss_ready got %b exp 0", miss_ready); end
    checks++; if ({rsp_valid, mem_req_valid, mem_rsp_ready, fill_done} !== 4'b0)
      begin errors++; $display("FAIL reset_valids got %b exp 0000", {rsp_valid, mem_req_valid, mem_rsp_ready, fill_done}); end
    checks++; if ({sram_csb0, sram_web0} !== 2'b11) begin errors++; $display("FAIL reset_csb_web got %b exp 11", {sram_csb0, sram_web0}); end
    checks++; if ({sram_wmask0, sram_addr0, sram_din0} !== '0)
      begin errors++; $display("FAIL reset_sram_bus got %h/%h/%h exp 0", sram_wmask0, sram_addr0, sram_din0); end
    tick(); idle_inputs(); rst_n = 1; mid();
    checks++; if ({miss_ready, rd_ready, sram_csb0} !== 3'b111)
      begin errors++; $display("FAIL post_reset_idle got %b exp 111", {miss_ready, rd_ready, sram_csb0}); end
  endtask

  task automatic test_read();
    tick(); rd_valid = 1; rd_addr = 7'h05; mid();
    checks++; if ({rd_ready, sram_csb0, sram_web0, sram_addr0} !== {1'b1, 1'b0, 1'b1, 7'h05})
      begin errors++; $display("FAIL read_drive got %b%b%b/%h exp 101/05", rd_ready, sram_csb0, sram_web0, sram_addr0); end
    tick(); rd_valid = 0; mid();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL read_t1_valid got %b exp 0", rsp_valid); end
    tick(); mid();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL read_t2_valid got %b exp 1", rsp_valid); end
    checks++; if (rsp_data !== 64'hDEADBEEF_CAFEF00D) begin errors++; $display("FAIL read_t2_data got %h exp deadbeefcafef00d", rsp_data); end
    tick(); mid();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL read_t3_valid got %b exp 0", rsp_valid); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 6; k++) begin
      tick(); rd_valid = (k < 3); rd_addr = 7'(20 + k); mid();
      checks++; if (rsp_valid !== (k >= 2 && k <= 4))
        begin errors++; $display("FAIL b2b_valid k=%0d got %b exp %b", k, rsp_valid, (k >= 2 && k <= 4)); end
      if (k >= 2 && k <= 4) begin
        checks++; if (rsp_data !== bg(18 + k)) begin errors++; $display("FAIL b2b_data k=%0d got %h exp %h", k, rsp_data, bg(18 + k)); end
      end
    end
  endtask

  task automatic test_fill();
    tick(); miss_valid = 1; miss_set = 5'd3; miss_word = 2'd0; mid();
    checks++; if (miss_ready !== 1'b1) begin errors++; $display("FAIL fill_miss_ready got %b exp 1", miss_ready); end
    tick(); miss_valid = 0; mem_req_ready = 0; rd_valid = 1; rd_addr = 7'd1; mid();
    checks++; if ({mem_req_valid, mem_req_set, mem_req_word, rd_ready} !== {1'b1, 5'd3, 2'd0, 1'b0})
      begin errors++; $display("FAIL fill_req got %b/%h/%h/%b exp 1/03/0/0", mem_req_valid, mem_req_set, mem_req_word, rd_ready); end
    tick(); mem_req_ready = 1; mid();
    checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL fill_req_hold got %b exp 1", mem_req_valid); end
    for (int i = 0; i < 4; i++) begin
      tick(); mem_req_ready = 0; mem_rsp_valid = 0; mid();
      checks++; if ({mem_rsp_ready, sram_csb0, rd_ready} !== 3'b110)
        begin errors++; $display("FAIL fill_gap%0d got %b exp 110", i, {mem_rsp_ready, sram_csb0, rd_ready}); end
      tick(); mem_rsp_valid = 1; mem_rsp_data = 64'h11 * 64'(i + 1); mid();
      checks++; if ({sram_csb0, sram_web0, sram_wmask0, sram_addr0, fill_done} !== {1'b0, 1'b0, 8'hFF, 7'(12 + i), 1'b0})
        begin errors++; $display("FAIL fill_beat%0d got %b%b/%h/%0d exp 00/ff/%0d", i, sram_csb0, sram_web0, sram_wmask0, sram_addr0, 12 + i); end
      checks++; if (sram_din0 !== 64'h11 * 64'(i + 1)) begin errors++; $display("FAIL fill_din%0d got %h exp %h", i, sram_din0, 64'h11 * 64'(i + 1)); end
    end
    tick(); mem_rsp_valid = 0; mid();
    checks++; if ({fill_done, rd_ready, mem_rsp_ready} !== 3'b100)
      begin errors++; $display("FAIL fill_done got %b exp 100", {fill_done, rd_ready, mem_rsp_ready}); end
    tick(); rd_valid = 0; mid();
    checks++; if ({fill_done, miss_ready} !== 2'b01) begin errors++; $display("FAIL fill_after got %b exp 01", {fill_done, miss_ready}); end
    tick(); rd_valid = 1; rd_addr = 7'd14;
    tick(); rd_valid = 0;
    tick(); mid();
    checks++; if ({rsp_valid, rsp_data} !== {1'b1, 64'h33}) begin errors++; $display("FAIL fill_readback got %b/%h exp 1/33", rsp_valid, rsp_data); end
  endtask

  task automatic test_miss_priority();
    tick(); miss_valid = 1; rd_valid = 1; rd_addr = 7'd5; miss_set = 5'd1; miss_word = 2'd3; mid();
    checks++; if ({miss_ready, rd_ready, sram_csb0} !== 3'b101)
      begin errors++; $display("FAIL prio_idle got %b exp 101", {miss_ready, rd_ready, sram_csb0}); end
    tick(); miss_valid = 0; mem_req_ready = 1; mid();
    checks++; if ({mem_req_valid, mem_req_word, rd_ready} !== {1'b1, CWF_REQ_WORD, 1'b0})
      begin errors++; $display("FAIL prio_req got %b/%0d/%b exp 1/%0d/0", mem_req_valid, mem_req_word, rd_ready, CWF_REQ_WORD); end
    for (int k = 0; k < 4; k++) begin
      tick(); mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 64'hB0 + 64'(k); mid();
      checks++; if ({sram_web0, sram_addr0, rd_ready} !== {1'b0, CWF_ADDR[k], 1'b0})
        begin errors++; $display("FAIL cwf_beat%0d got %b/%0d/%b exp 0/%0d/0", k, sram_web0, sram_addr0, rd_ready, CWF_ADDR[k]); end
    end
    tick(); mem_rsp_valid = 0; mid();
    checks++; if ({fill_done, rd_ready} !== 2'b10) begin errors++; $display("FAIL prio_done got %b exp 10", {fill_done, rd_ready}); end
    tick(); mid();
    checks++; if ({rd_ready, sram_csb0, sram_web0, sram_addr0} !== {3'b101, 7'd5})
      begin errors++; $display("FAIL prio_read_accept got %b%b%b/%0d exp 101/5", rd_ready, sram_csb0, sram_web0, sram_addr0); end
    tick(); rd_valid = 0;
    tick(); mid();
    checks++; if ({rsp_valid, rsp_data} !== {1'b1, CWF_RD5})
      begin errors++; $display("FAIL prio_readback got %b/%h exp 1/%h", rsp_valid, rsp_data, CWF_RD5); end
  endtask

  task automatic test_read_before_fill();
    tick(); rd_valid = 1; rd_addr = 7'd8;
    tick(); rd_valid = 0; miss_valid = 1; miss_set = 5'd2; miss_word = 2'd0;
    tick(); miss_valid = 0; mem_req_ready = 1; mid();
    checks++; if ({rsp_valid, rsp_data} !== {1'b1, bg(8)})
      begin errors++; $display("FAIL prefill_read got %b/%h exp 1/%h", rsp_valid, rsp_data, bg(8)); end
    for (int k = 0; k < 4; k++) begin
      tick(); mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 64'hC0 + 64'(k);
    end
    tick(); mem_rsp_valid = 0; mid();
    checks++; if (fill_done !== 1'b1) begin errors++; $display("FAIL prefill_done got %b exp 1", fill_done); end
    tick(); rd_valid = 1; rd_addr = 7'd8;
    tick(); rd_valid = 0;
    tick(); mid();
    checks++; if (rsp_data !== 64'hC0) begin errors++; $display("FAIL prefill_after got %h exp c0", rsp_data); end
  endtask

  task automatic test_reset_mid_fill();
    tick(); miss_valid = 1; miss_set = 5'd6; miss_word = 2'd0;
    tick(); miss_valid = 0; mem_req_ready = 1;
    tick(); mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 64'hD0;
    tick(); mem_rsp_data = 64'hD1;
    tick(); mem_rsp_data = 64'hD2; rst_n = 0; mid();
    checks++; if ({sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0} !== {2'b11, 79'd0})
      begin errors++; $display("FAIL midrst_sram got %b%b/%h/%h/%h exp 11/0", sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0); end
    checks++; if ({mem_rsp_ready, miss_ready, fill_done} !== 3'b000)
      begin errors++; $display("FAIL midrst_hs got %b exp 000", {mem_rsp_ready, miss_ready, fill_done}); end
    tick(); rst_n = 1; mem_rsp_valid = 0; mid();
    checks++; if (miss_ready !== 1'b1) begin errors++; $display("FAIL midrst_idle got %b exp 1", miss_ready); end
    tick(); rd_valid = 1; rd_addr = 7'd25;
    tick(); rd_addr = 7'd26;
    tick(); rd_valid = 0; mid();
    checks++; if (rsp_data !== 64'hD1) begin errors++; $display("FAIL midrst_partial got %h exp d1", rsp_data); end
    tick(); mid();
    checks++; if (rsp_data !== bg(26)) begin errors++; $display("FAIL midrst_abandoned got %h exp %h", rsp_data, bg(26)); end
    tick(); miss_valid = 1; miss_set = 5'd6;
    tick(); miss_valid = 0; mem_req_ready = 1;
    for (int k = 0; k < 4; k++) begin
      tick(); mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 64'hE0 + 64'(k); mid();
      checks++; if (sram_addr0 !== 7'(24 + k)) begin errors++; $display("FAIL refill_addr%0d got %0d exp %0d", k, sram_addr0, 24 + k); end
    end
    tick(); mem_rsp_valid = 0; mid();
    checks++; if (fill_done !== 1'b1) begin errors++; $display("FAIL refill_done got %b exp 1", fill_done); end
    tick(); rd_valid = 1; rd_addr = 7'd26;
    tick(); rd_valid = 0;
    tick(); mid();
    checks++; if (rsp_data !== 64'hE2) begin errors++; $display("FAIL refill_readback got %h exp e2", rsp_data); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_back_to_back();
    test_fill();
    test_miss_priority();
    test_read_before_fill();
    test_reset_mid_fill();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule : tb_icache_way_fill_ctrl
`default_nettype wire
